fetch_control_unit: RTL
=======================

Name: fetch_control_unit

Overview:
- Central front-end sequencer for the 5-stage RV32IM pipeline.
- Drives the fetch stage controls (pc_en, flush, jump_en, pc_jump_addr) and the IF/ID and ID/EX pipeline-register enables and bubbles.
- Arbitrates boot, halt/resume, branch/jump redirect, multiply/divide busy stalls and load-use stalls by a fixed priority.
- Keeps saturating stall and flush event counters for performance monitoring.

Parameters:
- BOOT_CYCLES, 2, cycles after reset release during which fetch is held and instruction memory output is forced to NOP; legal range 1..15.
- CNT_W, 32, width of each performance counter.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous active-high reset
- branch_taken_ex  in  1  EX stage resolved a taken branch or jump this cycle
- branch_target_ex  in  32  redirect target from EX
- md_busy  in  1  multi-cycle multiply/divide occupying EX
- load_use_hazard  in  1  ID instruction depends on a load currently in EX
- halt_req  in  1  ebreak/ecall retiring in WB (single-cycle pulse)
- resume  in  1  external resume pulse
- cnt_clr  in  1  synchronous clear of both counters
- pc_en  out  1  PC advance and instruction-memory read enable
- flush  out  1  instruction memory forces a NOP on its next output
- jump_en  out  1  PC mux selects pc_jump_addr
- pc_jump_addr  out  32  redirect target
- if_id_en  out  1  IF/ID register load enable
- if_id_flush  out  1  IF/ID register clears to NOP
- id_ex_en  out  1  ID/EX register load enable
- id_ex_bubble  out  1  ID/EX register loads a NOP
- halted  out  1  core is halted
- stall_cnt  out  CNT_W  cycles with pc_en=0 while in RUN
- flush_cnt  out  CNT_W  number of redirects taken

Behaviour:
- States: BOOT, RUN, HALT; 2-bit state register plus a 4-bit boot counter.
- Reset (async) puts the block in BOOT with boot counter = 0 and both counters = 0.
- Output values during reset:
  - pc_en=0, flush=1, jump_en=0, pc_jump_addr=0.
  - if_id_en=0, if_id_flush=1, id_ex_en=1, id_ex_bubble=1.
  - halted=0.
- BOOT:
  - Outputs are the same as during reset.
  - Boot counter increments each cycle; on the cycle it reaches BOOT_CYCLES-1, the next state is RUN.
  - All inputs are ignored.
- RUN: outputs are combinational from the inputs in this fixed priority (highest first).
  1. halt_req: pc_en=0, if_id_en=0, id_ex_bubble=1, flush=1, if_id_flush=1; next state HALT.
  2. md_busy: pc_en=0, if_id_en=0, id_ex_en=0, id_ex_bubble=0; EX is held. branch_taken_ex is ignored in this case.
  3. branch_taken_ex: jump_en=1, pc_jump_addr=branch_target_ex, pc_en=1, flush=1, if_id_flush=1, id_ex_bubble=1. The two wrong-path instructions are squashed; the target is fetched the next cycle. flush_cnt increments.
  4. load_use_hazard: pc_en=0, if_id_en=0, id_ex_bubble=1, which gives one bubble per asserted cycle.
  5. Otherwise: pc_en=1, if_id_en=1, id_ex_en=1, all flush and bubble outputs 0, jump_en=0.
- pc_jump_addr equals branch_target_ex whenever jump_en=1, and 0 otherwise.
- stall_cnt increments on every RUN cycle where pc_en=0, including the halt_req cycle.
- Both counters saturate at all-ones. cnt_clr has priority over increment; a clear in the same cycle as an event leaves the counter at 0.
- HALT:
  - halted=1, pc_en=0, if_id_en=0, id_ex_bubble=1, flush=0, if_id_flush=0.
  - Counters are frozen.
  - resume moves the block to RUN on the next edge. resume in any other state is ignored.
  - halt_req while in HALT is ignored.
- Reset asserted mid-operation (any state) returns the block to BOOT immediately. A redirect in flight is discarded.
- Latency:
  - Redirect takes effect at the PC in the same cycle (0 registered latency); the first target instruction is fetched at T+1.
  - Halt takes effect at T+1.

Decomposition:
- Shared pipeline package holds:
  - State encoding: BOOT=2'd0, RUN=2'd1, HALT=2'd2.
  - NOP constant 32'h00000013.
  - Default BOOT_CYCLES.
- One natural sub-module: perf_counter (saturating, with synchronous clear, width CNT_W), instantiated twice for stall_cnt and flush_cnt.

Test Plan:
1. Reset released with BOOT_CYCLES=2 -> pc_en=0 and flush=1 for exactly 2 cycles; pc_en=1 on the 3rd cycle; stall_cnt stays 0.
2. RUN, pulse branch_taken_ex with branch_target_ex=32'h0000_0040 -> that cycle: jump_en=1, pc_jump_addr=32'h40, flush=1, if_id_flush=1, id_ex_bubble=1; flush_cnt=1; next cycle all flush outputs are 0.
3. md_busy held 4 cycles with branch_taken_ex=1 in cycle 2 -> pc_en=0 and id_ex_en=0 for 4 cycles; jump_en stays 0; stall_cnt=4; flush_cnt=0.
4. load_use_hazard for 1 cycle together with branch_taken_ex -> redirect wins (jump_en=1, pc_en=1); load_use alone next cycle -> pc_en=0, id_ex_bubble=1; stall_cnt=1.
5. halt_req pulse -> halted=1 from the next cycle; resume asserted after 5 cycles -> RUN on the next edge; halt_req during HALT is ignored; counters unchanged during HALT.
6. CNT_W=4, 20 stall cycles -> stall_cnt saturates at 4'hF; cnt_clr coincident with a stall cycle -> 0; async rst mid-HALT -> BOOT immediately with all outputs at reset values.

Source files
------------

// File: rtl/fetch_control_unit_pkg.sv
// Shared definitions for the RV32IM front-end control slice.
// Holds the sequencer state encoding, the NOP instruction word and the
// default boot hold length used by fetch_control_unit.
package fetch_control_unit_pkg;

  // Sequencer states: BOOT holds fetch, RUN arbitrates, HALT parks the core.
  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } fcu_state_e;

  // addi x0, x0, 0 -- the canonical RV32 NOP injected by flushes and bubbles.
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  // Default number of cycles fetch is held after reset release.
  localparam int BOOT_CYCLES_DEF = 2;

endpackage

// File: rtl/fetch_control_unit_perf_counter.sv
// perf_counter: saturating event counter with synchronous clear.
// Ports:
//   clk, rst : clock and asynchronous active-high reset
//   clr      : synchronous clear, wins over inc
//   inc      : count one event this cycle
//   cnt      : current count, sticks at all-ones
module perf_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  localparam logic [W-1:0] CNT_MAX = {W{1'b1}};

  // Count register: clear first, then saturating increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= {W{1'b0}};
    end else if (clr) begin
      cnt <= {W{1'b0}};
    end else if (inc && (cnt != CNT_MAX)) begin
      cnt <= cnt + W'(1);
    end else begin
      cnt <= cnt;
    end
  end

endmodule

// File: rtl/fetch_control_unit.sv
// fetch_control_unit: front-end sequencer for the 5-stage RV32IM pipeline.
// Holds fetch for BOOT_CYCLES after reset, then arbitrates halt, mul/div
// busy, branch redirect and load-use stalls by fixed priority. In RUN the
// control outputs are combinational from the hazard inputs so a redirect
// reaches the PC mux in the same cycle.
// Ports:
//   clk, rst                          : clock, async active-high reset
//   branch_taken_ex, branch_target_ex : EX redirect request and target
//   md_busy, load_use_hazard          : stall sources
//   halt_req, resume                  : halt entry / exit pulses
//   cnt_clr                           : clear of both perf counters
//   pc_en, flush, jump_en, pc_jump_addr : fetch stage controls
//   if_id_en, if_id_flush             : IF/ID register controls
//   id_ex_en, id_ex_bubble            : ID/EX register controls
//   halted                            : core parked in HALT
//   stall_cnt, flush_cnt              : saturating perf counters
module fetch_control_unit
  import fetch_control_unit_pkg::*;
#(
  parameter int BOOT_CYCLES = BOOT_CYCLES_DEF,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             branch_taken_ex,
  input  logic [31:0]      branch_target_ex,
  input  logic             md_busy,
  input  logic             load_use_hazard,
  input  logic             halt_req,
  input  logic             resume,
  input  logic             cnt_clr,
  output logic             pc_en,
  output logic             flush,
  output logic             jump_en,
  output logic [31:0]      pc_jump_addr,
  output logic             if_id_en,
  output logic             if_id_flush,
  output logic             id_ex_en,
  output logic             id_ex_bubble,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  // Boot counter value on the last held cycle.
  localparam logic [3:0] BOOT_LAST = 4'(BOOT_CYCLES - 1);

  fcu_state_e  state_r;
  fcu_state_e  state_nxt_s;
  logic [3:0]  boot_cnt_r;
  logic [3:0]  boot_cnt_nxt_s;
  logic        stall_evt_s;
  logic        flush_evt_s;

  // State and boot counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= ST_BOOT;
      boot_cnt_r <= 4'd0;
    end else begin
      state_r    <= state_nxt_s;
      boot_cnt_r <= boot_cnt_nxt_s;
    end
  end

  // Next-state and pipeline control outputs. Defaults are the reset/BOOT
  // values; RUN overrides them per the hazard priority.
  always_comb begin
    state_nxt_s    = state_r;
    boot_cnt_nxt_s = boot_cnt_r;
    pc_en          = 1'b0;
    flush          = 1'b1;
    jump_en        = 1'b0;
    if_id_en       = 1'b0;
    if_id_flush    = 1'b1;
    id_ex_en       = 1'b1;
    id_ex_bubble   = 1'b1;
    halted         = 1'b0;
    stall_evt_s    = 1'b0;
    flush_evt_s    = 1'b0;

    case (state_r)
      ST_BOOT: begin
        if (boot_cnt_r == BOOT_LAST) begin
          state_nxt_s    = ST_RUN;
          boot_cnt_nxt_s = 4'd0;
        end else begin
          boot_cnt_nxt_s = boot_cnt_r + 4'd1;
        end
      end

      ST_RUN: begin
        // Free-running fetch unless a hazard below overrides it.
        pc_en        = 1'b1;
        flush        = 1'b0;
        if_id_en     = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_bubble = 1'b0;
        if (halt_req) begin
          pc_en        = 1'b0;
          if_id_en     = 1'b0;
          id_ex_bubble = 1'b1;
          flush        = 1'b1;
          if_id_flush  = 1'b1;
          state_nxt_s  = ST_HALT;
        end else if (md_busy) begin
          // EX keeps the multi-cycle op; a branch resolving now is not real.
          pc_en    = 1'b0;
          if_id_en = 1'b0;
          id_ex_en = 1'b0;
        end else if (branch_taken_ex) begin
          jump_en      = 1'b1;
          flush        = 1'b1;
          if_id_flush  = 1'b1;
          id_ex_bubble = 1'b1;
          flush_evt_s  = 1'b1;
        end else if (load_use_hazard) begin
          pc_en        = 1'b0;
          if_id_en     = 1'b0;
          id_ex_bubble = 1'b1;
        end else begin
          pc_en = 1'b1;
        end
        stall_evt_s = ~pc_en;
      end

      ST_HALT: begin
        halted      = 1'b1;
        flush       = 1'b0;
        if_id_flush = 1'b0;
        if (resume) begin
          state_nxt_s = ST_RUN;
        end else begin
          state_nxt_s = ST_HALT;
        end
      end

      default: begin
        state_nxt_s    = ST_BOOT;
        boot_cnt_nxt_s = 4'd0;
      end
    endcase
  end

  assign pc_jump_addr = jump_en ? branch_target_ex : 32'd0;

  perf_counter #(.W(CNT_W)) u_stall_cnt (
    .clk (clk),
    .rst (rst),
    .clr (cnt_clr),
    .inc (stall_evt_s),
    .cnt (stall_cnt)
  );

  perf_counter #(.W(CNT_W)) u_flush_cnt (
    .clk (clk),
    .rst (rst),
    .clr (cnt_clr),
    .inc (flush_evt_s),
    .cnt (flush_cnt)
  );

endmodule
